// File: rtl/bit_serializer_pkg.sv
// Shared types and width helpers for the bit serializer and its bit-period divider.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_serializer_ce.sv
// ce_divider: free-running bit-period counter that strobes tick in the last cycle of each period.
module ce_divider
  import bit_serializer_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// LSB-first parallel-to-serial converter with a d/enable strobe pair for a downstream enabled flop.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit period to every frame.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  // Handshake: a word is taken on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so in_valid while busy is simply dropped.

  localparam int IW = cnt_w(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             clear;
  logic             run;
  logic             tick;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign run      = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);
  assign busy     = run;
  assign enable   = tick;
  assign done     = done_q;
  // The shift register's LSB is the registered serial output; it is zero whenever idle.
  assign d        = sh_q[0];

  ce_divider #(.DIV(DIV)) u_ce_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clear   = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          idx_d   = '0;
          clear   = 1'b1;
          state_d = SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            sh_d    = {{(WIDTH-1){1'b0}}, par_q};
            state_d = PARITY;
`else
            sh_d    = '0;
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            sh_d  = {1'b0, sh_q[WIDTH-1:1]};
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (tick) begin
          sh_d    = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        sh_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a frame-level reference model checked every cycle plus directed literal checks.
module tb_bit_serializer;

  localparam int W  = 8;
  localparam int DV = 4;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] in_data, in_data1;
  logic in_valid, in_valid1;
  logic in_ready, d, enable, busy, done;
  logic in_ready1, d1, enable1, busy1, done1;

  bit_serializer #(.WIDTH(W), .DIV(DV)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .d(d), .enable(enable), .busy(busy), .done(done)
  );

  bit_serializer #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .d(d1), .enable(enable1), .busy(busy1), .done(done1)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word occupies NB*DV cycles; cycle c carries frame bit (c-1)/DV.
  logic         m_busy, m_done;
  int           m_c;
  logic [W-1:0] m_word;

  function automatic logic fbit(input logic [W-1:0] w, input int i);
    if (i < W) return w[i];
    return ^w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_c    <= 0;
      m_word <= '0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (in_valid) begin
        m_busy <= 1'b1;
        m_c    <= 1;
        m_word <= in_data;
      end
    end else if (m_c == NB * DV) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
    end else begin
      m_c <= m_c + 1;
    end
  end

  // Compare process: {d, enable, busy, done, in_ready} every cycle.
  always @(negedge clk) begin
    logic [4:0] e;
    if (chk_en && rst_n) begin
      e = {m_busy ? fbit(m_word, (m_c - 1) / DV) : 1'b0,
           m_busy && ((m_c % DV) == 0), m_busy, m_done, !m_busy};
      check("cycle", {27'd0, d, enable, busy, done, in_ready}, {27'd0, e});
    end
  end

  // driver: waits for the acceptance edge, then records strobed bits until done
  logic         hold_next;
  logic [W-1:0] next_data;

  task automatic capture(output logic [8:0] bits, output int done_cyc, output int en_cnt);
    bits = '0;
    done_cyc = -1;
    en_cnt = 0;
    @(posedge clk);
    #1;
    if (hold_next) in_data = next_data;
    else in_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (enable) begin
        if (en_cnt < 9) bits[en_cnt] = d;
        en_cnt++;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic run_word(input logic [W-1:0] w, input string name);
    logic [8:0] bits;
    int dc, ec;
    @(posedge clk);
    #1;
    in_data  = w;
    in_valid = 1'b1;
    capture(bits, dc, ec);
    check({name, "_bits"}, {24'd0, bits[W-1:0]}, {24'd0, w});
    check({name, "_en_cnt"}, ec, NB);
    check({name, "_done_cyc"}, dc, NB * DV + 1);
`ifdef BIT_SERIALIZER_PARITY_EN
    check({name, "_parity"}, {31'd0, bits[8]}, {31'd0, ^w});
`endif
  endtask

  initial begin
    logic [8:0] bits;
    int dc, ec;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    hold_next = 1'b0;
    next_data = '0;
    rst_n     = 1'b0;
    #12;
    check("reset_state", {27'd0, d, enable, busy, done, in_ready}, 32'b00001);
    check("reset_state1", {27'd0, d1, enable1, busy1, done1, in_ready1}, 32'b00001);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // A5: bits 1,0,1,0,0,1,0,1 LSB first, done in cycle 33 (37 with parity 0)
    run_word(8'hA5, "a5");
    // 01: parity bit is 1 when enabled
    run_word(8'h01, "w01");

    // in_valid held with 3C during the A5 frame
    @(posedge clk);
    #1;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    hold_next = 1'b1;
    next_data = 8'h3C;
    capture(bits, dc, ec);
    check("hold_a5_bits", {24'd0, bits[7:0]}, 32'hA5);
    check("hold_a5_done", dc, NB * DV + 1);
    check("hold_ready_at_done", {31'd0, in_ready}, 32'd1);
    hold_next = 1'b0;
    capture(bits, dc, ec);
    check("hold_3c_bits", {24'd0, bits[7:0]}, 32'h3C);
    check("hold_3c_done", dc, NB * DV + 1);

    // DIV=1 instance with FF
    @(posedge clk);
    #1;
    in_data1  = 8'hFF;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    for (int k = 1; k <= NB + 1; k++) begin
      @(negedge clk);
      if (k <= W) check("div1_bit", {28'd0, d1, enable1, busy1, done1}, 32'b1110);
      else if (k <= NB) check("div1_parity", {28'd0, d1, enable1, busy1, done1}, 32'b0110);
      else check("div1_done", {30'd0, done1, in_ready1}, 32'b11);
    end

    // reset in cycle 14 of an A5 frame
    @(posedge clk);
    #1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {28'd0, d, enable, busy, done}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    run_word(8'h5A, "post_rst");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
